// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : if_pkg
//  Brief   : Shared types and constants for the instruction-fetch unit.
//            FSM state encoding, default reset PC / bubble instruction and
//            the PC increment.
//  Revision: 1.0 - initial release
// ============================================================================
package if_pkg;

  // Fetch FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding or being issued
    DRAIN = 2'd1,  // discarding a response after a redirect
    SKID  = 2'd2   // downstream stalled, one word parked in the skid
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage : if_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_skid_buf
//  Brief   : One-entry {instruction, pc} holding buffer used when the IF/ID
//            stage is stalled while a memory response arrives.
//  Ports   : clk, reset      - clock, synchronous active-high reset
//            i_load          - capture i_inst / i_pc, mark entry valid
//            i_clear         - drop the entry (wins over i_load)
//            i_inst, i_pc    - data to park
//            o_valid         - entry holds data
//            o_inst, o_pc    - parked data
//  Revision: 1.0 - initial release
// ============================================================================
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_inst  <= 32'h0;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : if_fetch_unit
//  Brief   : Instruction fetch, producer side of IF/ID. Owns the PC, issues
//            word reads over a req/ack handshake, absorbs stalls with a
//            one-entry skid and handles branch/jump redirects. The IF/ID
//            register samples every cycle, so stalls hold these outputs and
//            flushes bubble them.
//  Ports   : clk, reset                 - clock, sync active-high reset
//            i_stall                    - hold IF outputs this edge
//            i_redirect, i_redirect_pc  - flush and refetch at target
//            o_imem_req, o_imem_addr    - memory read request / word address
//            i_imem_ack, i_imem_rdata   - read response
//            o_inst, o_PC, o_PC_plus_4  - fetched instruction and its PCs
//            o_valid                    - outputs hold a real instruction
//  Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_PC,
  output logic [31:0] o_PC_plus_4,
  output logic        o_valid
);

  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_pc,    w_pc_n;
  logic [31:0]  r_redir, w_redir_n;
  logic         r_valid, w_valid_n;
  logic [31:0]  r_inst,  w_inst_n;
  logic [31:0]  r_opc,   w_opc_n;
  logic [31:0]  r_opc4,  w_opc4_n;

  logic         w_skid_load;
  logic         w_skid_clear;
  logic         w_skid_valid;
  logic [31:0]  w_skid_inst;
  logic [31:0]  w_skid_pc;

  logic         w_blocked;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;
  logic         w_unused;

  // Redirect targets are word aligned; low bits are discarded.
  assign w_target  = {i_redirect_pc[31:2], 2'b00};
  assign w_unused  = ^i_redirect_pc[1:0];
  assign w_pc_inc  = r_pc + PC_INC;
  // Downstream only refuses an instruction it actually holds.
  assign w_blocked = r_valid && i_stall;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_inst  (i_imem_rdata),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_redir_n    = r_redir;
    w_valid_n    = r_valid;
    w_inst_n     = r_inst;
    w_opc_n      = r_opc;
    w_opc4_n     = r_opc4;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;

    if (i_redirect) begin
      // Redirect overrides stall: flush outputs and skid unconditionally.
      w_valid_n    = 1'b0;
      w_inst_n     = NOP_INST;
      w_skid_clear = 1'b1;
      unique case (r_state)
        FETCH: begin
          if (i_imem_ack) begin
            w_pc_n = w_target;
          end else begin
            // Request still in flight: remember target, swallow the response.
            w_redir_n = w_target;
            w_state_n = DRAIN;
          end
        end
        DRAIN: begin
          if (i_imem_ack) begin
            w_pc_n    = w_target;
            w_state_n = FETCH;
          end else begin
            w_redir_n = w_target;
          end
        end
        SKID: begin
          w_pc_n    = w_target;
          w_state_n = FETCH;
        end
        default: begin
          w_pc_n    = w_target;
          w_state_n = FETCH;
        end
      endcase
    end else begin
      unique case (r_state)
        FETCH: begin
          if (i_imem_ack && !w_blocked) begin
            w_inst_n  = i_imem_rdata;
            w_opc_n   = r_pc;
            w_opc4_n  = w_pc_inc;
            w_valid_n = 1'b1;
            w_pc_n    = w_pc_inc;
          end else if (i_imem_ack) begin
            w_skid_load = 1'b1;
            w_pc_n      = w_pc_inc;
            w_state_n   = SKID;
          end else if (!w_blocked) begin
            w_valid_n = 1'b0;
            w_inst_n  = NOP_INST;
          end
        end
        DRAIN: begin
          w_valid_n = 1'b0;
          w_inst_n  = NOP_INST;
          if (i_imem_ack) begin
            w_pc_n    = r_redir;
            w_state_n = FETCH;
          end
        end
        SKID: begin
          if (!i_stall && w_skid_valid) begin
            w_inst_n     = w_skid_inst;
            w_opc_n      = w_skid_pc;
            w_opc4_n     = w_skid_pc + PC_INC;
            w_valid_n    = 1'b1;
            w_skid_clear = 1'b1;
            w_state_n    = FETCH;
          end
        end
        default: begin
          w_state_n = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_redir <= RESET_PC;
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_opc   <= 32'h0;
      r_opc4  <= 32'h0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_redir <= w_redir_n;
      r_valid <= w_valid_n;
      r_inst  <= w_inst_n;
      r_opc   <= w_opc_n;
      r_opc4  <= w_opc4_n;
    end
  end

  // Request drops combinationally with reset so an in-flight read is abandoned.
  assign o_imem_req  = !reset && ((r_state == FETCH) || (r_state == DRAIN));
  assign o_imem_addr = r_pc;
  assign o_inst      = r_inst;
  assign o_PC        = r_opc;
  assign o_PC_plus_4 = r_opc4;
  assign o_valid     = r_valid;

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_if_fetch_unit
//  Brief   : Directed, table-driven self-checking bench for if_fetch_unit.
//            Memory data is always address ^ KEY, so a presented instruction
//            is expected to equal o_PC ^ KEY.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_inst;
  logic [31:0] o_PC;
  logic [31:0] o_PC_plus_4;
  logic        o_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_inst        (o_inst),
    .o_PC          (o_PC),
    .o_PC_plus_4   (o_PC_plus_4),
    .o_valid       (o_valid)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic        exp_req;   // before the edge
    logic [31:0] exp_addr;  // before the edge
    logic        exp_valid; // after the edge
    logic [31:0] exp_pc;    // after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic a, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.ack = a;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic s, input logic r, input logic [31:0] rp,
                       input logic a, input logic [31:0] rd);
    @(negedge clk);
    reset = rst; i_stall = s; i_redirect = r; i_redirect_pc = rp;
    i_imem_ack = a; i_imem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] ep);
    check({tag, " valid"}, {31'h0, o_valid}, {31'h0, ev});
    check({tag, " inst"}, o_inst, ev ? (ep ^ KEY) : 32'h0);
    check({tag, " pc"}, o_PC, ep);
    check({tag, " pc4"}, o_PC_plus_4, ep + 32'd4);
  endtask

  initial begin
    reset = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_imem_ack = 1'b0; i_imem_rdata = 32'h0;

    // ---------------- reset state ----------------
    tick(); tick();
    @(negedge clk); #1;
    check("rst req", {31'h0, o_imem_req}, 32'h0);
    check("rst addr", o_imem_addr, 32'h3000);
    check("rst valid", {31'h0, o_valid}, 32'h0);
    check("rst inst", o_inst, 32'h0);
    check("rst pc", o_PC, 32'h0);
    check("rst pc4", o_PC_plus_4, 32'h0);

    // ---------------- directed vector table ----------------
    //                 stall redir rpc          ack req addr          valid pc
    // ack tied high: 1 instr/cycle
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_3000, 1, 32'h0000_3000));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_3004, 1, 32'h0000_3004));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_3008, 1, 32'h0000_3008));
    // ack delayed 3 cycles: bubbles, PC fields keep last value
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_300C, 0, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_300C, 0, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_300C, 0, 32'h0000_3008));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_300C, 1, 32'h0000_300C));
    // stall 2 cycles with ack: 3010 parked in skid, req drops
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h0000_3010, 1, 32'h0000_300C));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0000_3014, 1, 32'h0000_300C));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0000_3014, 1, 32'h0000_3010));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_3014, 1, 32'h0000_3014));
    // redirect to 4002 with ack in the same cycle
    vecs.push_back(mk(0, 1, 32'h0000_4002, 1, 1, 32'h0000_3018, 0, 32'h0000_3014));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_4000, 1, 32'h0000_4000));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_4004, 1, 32'h0000_4004));
    // redirect to 5000 while 4008 waits: DRAIN, 4008 data never shown
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_4008, 0, 32'h0000_4004));
    vecs.push_back(mk(0, 1, 32'h0000_5000, 0, 1, 32'h0000_4008, 0, 32'h0000_4004));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_4008, 0, 32'h0000_4004));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_4008, 0, 32'h0000_4004));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_5000, 1, 32'h0000_5000));
    // redirect with stall asserted: redirect wins
    vecs.push_back(mk(1, 1, 32'h0000_6000, 1, 1, 32'h0000_5004, 0, 32'h0000_5000));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h0000_6000, 1, 32'h0000_6000));
    // redirect while parked in skid: skid content discarded
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 32'h0000_6004, 1, 32'h0000_6000));
    vecs.push_back(mk(1, 1, 32'h0000_7000, 0, 0, 32'h0000_6008, 0, 32'h0000_6000));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_7000, 1, 32'h0000_7000));
    // second redirect during DRAIN overwrites the first
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h0000_7004, 0, 32'h0000_7000));
    vecs.push_back(mk(0, 1, 32'h0000_8000, 0, 1, 32'h0000_7004, 0, 32'h0000_7000));
    vecs.push_back(mk(0, 1, 32'h0000_9000, 0, 1, 32'h0000_7004, 0, 32'h0000_7000));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_7004, 0, 32'h0000_7000));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h0000_9000, 1, 32'h0000_9000));

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack,
            vecs[i].exp_addr ^ KEY);
      check($sformatf("v%0d req", i), {31'h0, o_imem_req}, {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d addr", i), o_imem_addr, vecs[i].exp_addr);
      tick();
      check_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // ---------------- PC wrap at top of address space ----------------
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h0);
    tick();
    check("wrap bubble", {31'h0, o_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC ^ KEY);
    check("wrap addr0", o_imem_addr, 32'hFFFF_FFFC);
    tick();
    check_out("wrap top", 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0 ^ KEY);
    check("wrap addr1", o_imem_addr, 32'h0);
    tick();
    check_out("wrap zero", 1'b1, 32'h0);

    // ---------------- reset mid-request, late ack, delayed ack ----------------
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mid req", {31'h0, o_imem_req}, 32'h1);
    check("mid addr", o_imem_addr, 32'h4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rst drop req", {31'h0, o_imem_req}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4 ^ KEY);
    check("late ack req", {31'h0, o_imem_req}, 32'h0);
    tick();
    check("rst2 valid", {31'h0, o_valid}, 32'h0);
    check("rst2 inst", o_inst, 32'h0);
    check("rst2 pc", o_PC, 32'h0);
    check("rst2 pc4", o_PC_plus_4, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4 ^ KEY);
      check($sformatf("wait%0d req", k), {31'h0, o_imem_req}, 32'h1);
      check($sformatf("wait%0d addr", k), o_imem_addr, 32'h3000);
      tick();
      check($sformatf("wait%0d valid", k), {31'h0, o_valid}, 32'h0);
      check($sformatf("wait%0d inst", k), o_inst, 32'h0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000 ^ KEY);
    check("post rst addr", o_imem_addr, 32'h3000);
    tick();
    check_out("post rst", 1'b1, 32'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Producer side of the IF/ID interface. Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents `o_inst`, `o_PC`, `o_PC_plus_4` and `o_valid` to the IF/ID register, which samples every cycle and has no enable. Stalls and flushes are therefore realised here, by holding or bubbling these outputs.
- Handles variable memory latency, stall back-pressure (1-entry skid) and branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, instruction word driven when `o_valid`=0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- i_stall  in  1  hazard unit: hold current IF outputs this edge
- i_redirect  in  1  taken branch/jump: flush and refetch
- i_redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 00
- o_imem_req  out  1  memory read request
- o_imem_addr  out  32  word address (= `pc_q`)
- i_imem_ack  in  1  read data valid; may be high in the same cycle as req
- i_imem_rdata  in  32  instruction word
- o_inst  out  32  fetched instruction
- o_PC  out  32  address of `o_inst`
- o_PC_plus_4  out  32  `o_PC`+4, modulo 2^32
- o_valid  out  1  outputs hold a real instruction

Behaviour:
- One clock, `clk`; `reset` synchronous active-high.
- Registers: `pc_q`, `redir_q`, `state`, skid {data, pc}, and the output regs.
- Reset values:
  - `pc_q` = RESET_PC, `state` = FETCH.
  - `o_valid` = 0, `o_inst` = NOP_INST, `o_PC` = 0, `o_PC_plus_4` = 0.
  - Skid empty.
- `o_imem_req` = !reset && (state==FETCH || state==DRAIN).
- `o_imem_addr` = `pc_q` (held stable while req=1 and ack=0).
- Reset asserted mid-request: the request is abandoned and any later ack is ignored.
- "Blocked" = `o_valid` && `i_stall`. When not blocked, the IF/ID register consumes the outputs at the edge.
- Priority at each edge: reset > redirect > ack/stall handling.
- FETCH state:
  - ack && !blocked: `o_inst` <= rdata, `o_PC` <= `pc_q`, `o_PC_plus_4` <= `pc_q`+4, `o_valid` <= 1, `pc_q` <= `pc_q`+4. Sustained throughput with ack tied high is 1 instr/cycle.
  - ack && blocked: skid <= {rdata, `pc_q`}, `pc_q` <= `pc_q`+4, go to SKID. Outputs are held.
  - !ack && !blocked: `o_valid` <= 0 and `o_inst` <= NOP_INST (bubble). PC fields keep their last value.
  - !ack && blocked: hold all outputs.
- SKID state:
  - `o_imem_req` = 0.
  - !`i_stall`: outputs <= skid contents, `o_valid` <= 1, go to FETCH.
  - `i_stall`: hold.
- DRAIN state (redirect arrived while a request was outstanding):
  - req/addr stay on the old `pc_q`; `o_valid` = 0.
  - On ack: data discarded, `pc_q` <= `redir_q`, go to FETCH.
  - A new redirect while in DRAIN overwrites `redir_q`.
- Redirect handling (overrides stall):
  - Always: `o_valid` <= 0, `o_inst` <= NOP_INST, skid cleared.
  - FETCH with ack in the same cycle: data dropped, `pc_q` <= target, stay in FETCH.
  - FETCH without ack: `redir_q` <= target, go to DRAIN.
  - SKID: `pc_q` <= target, go to FETCH.
- Width and wrap: `pc_q` 32'hFFFF_FFFC + 4 wraps to 0, with no flag raised.
- Memory contract: at most one outstanding request.

Decomposition:
- Package `if_pkg`:
  - state encoding: FETCH=2'd0, DRAIN=2'd1, SKID=2'd2.
  - NOP_INST, RESET_PC defaults.
  - PC_INC=32'd4.
- One natural sub-module: `fetch_skid_buf`, a 1-entry {inst, pc} buffer with load/clear/valid.

Test Plan:
- Reset, ack tied 1, rdata=addr^32'hA5A5_A5A5:
  - first edge after reset deassert gives `o_PC`=0x3000, `o_valid`=1;
  - following edges give 0x3004, 0x3008;
  - `o_PC_plus_4`=`o_PC`+4 every cycle.
- Ack delayed 3 cycles:
  - req stays 1 and addr stays 0x3000 throughout;
  - `o_valid`=0 and `o_inst`=0 during the wait;
  - the instruction appears one edge after ack.
- Stall for 2 cycles with `o_PC`=0x3004 while ack=1:
  - outputs frozen at 0x3004;
  - 0x3008 parked in skid and req=0;
  - on release `o_PC`=0x3008, then 0x300C.
- Redirect to 0x4002 with no outstanding wait:
  - next outputs are a bubble (`o_valid`=0, `o_inst`=0);
  - then `o_PC`=0x4000.
- Redirect to 0x5000 while a request to 0x3010 waits for ack (ack after 2 cycles):
  - state enters DRAIN;
  - the 0x3010 data is never presented;
  - the next request address is 0x5000.
- Redirect with stall asserted, plus reset asserted while req=1:
  - redirect wins over stall;
  - on reset, req drops in the same cycle and the next fetch address is 0x3000;
  - a late ack is ignored.
